// File: rtl/ucsbece154b_bpred_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ucsbece154b_bpred_ctrl
//  Purpose  : Maintenance controller for the branch predictor PHT and BTB.
//             After reset or a flush it sweeps both tables to a known state
//             (PHT entries weakly-not-taken, BTB entries invalid). In normal
//             operation it queues E-stage branch/jump resolutions and
//             serializes them onto the single PHT and BTB write ports, one
//             update per cycle.
//  Ports    :
//    clk, reset_i (sync, active-low), flush_i (restart sweep, drop queue)
//    upd_*_i      : E-stage resolution record (pc, ghr, flags, target)
//    upd_full_o   : update queue holds FIFO_DEPTH records
//    busy_o       : sweep in progress, predictions not usable
//    pht_op_o/pht_addr_o                    : PHT command (NOP/INIT/INC/DEC)
//    btb_we_o/btb_inval_o/btb_addr_o/btb_target_o : BTB command
//    dropped_o    : saturating count of updates lost to a full queue
//  Revision : 1.0  initial release
// ============================================================================
module ucsbece154b_bpred_ctrl #(
  parameter int NUM_GHR_BITS    = 5,
  parameter int NUM_BTB_ENTRIES = 32,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                               clk,
  input  logic                               reset_i,
  input  logic                               flush_i,
  input  logic                               upd_valid_i,
  input  logic [31:0]                        upd_pc_i,
  input  logic [NUM_GHR_BITS-1:0]            upd_ghr_i,
  input  logic                               upd_branch_i,
  input  logic                               upd_jump_i,
  input  logic                               upd_taken_i,
  input  logic [31:0]                        upd_target_i,
  output logic                               upd_full_o,
  output logic                               busy_o,
  output logic [1:0]                         pht_op_o,
  output logic [NUM_GHR_BITS-1:0]            pht_addr_o,
  output logic                               btb_we_o,
  output logic                               btb_inval_o,
  output logic [$clog2(NUM_BTB_ENTRIES)-1:0] btb_addr_o,
  output logic [31:0]                        btb_target_o,
  output logic [7:0]                         dropped_o
);

  localparam int c_BI      = $clog2(NUM_BTB_ENTRIES);
  localparam int c_PHT_N   = 1 << NUM_GHR_BITS;
  localparam int c_SWEEP_N = (c_PHT_N > NUM_BTB_ENTRIES) ? c_PHT_N : NUM_BTB_ENTRIES;
  // One spare bit so the sweep limits compare cleanly against the counter.
  localparam int c_CW      = $clog2(c_SWEEP_N) + 1;
  localparam int c_PW      = $clog2(FIFO_DEPTH);
  localparam int c_OW      = c_PW + 1;

  localparam logic [c_CW-1:0] c_PHT_LIM  = c_CW'(c_PHT_N);
  localparam logic [c_CW-1:0] c_BTB_LIM  = c_CW'(NUM_BTB_ENTRIES);
  localparam logic [c_CW-1:0] c_LAST_IDX = c_CW'(c_SWEEP_N - 1);
  localparam logic [c_OW-1:0] c_FULL_CNT = c_OW'(FIFO_DEPTH);

  localparam logic [1:0] c_OP_NOP  = 2'd0;
  localparam logic [1:0] c_OP_INIT = 2'd1;
  localparam logic [1:0] c_OP_INC  = 2'd2;
  localparam logic [1:0] c_OP_DEC  = 2'd3;

  localparam logic [0:0] c_ST_INIT = 1'b0;
  localparam logic [0:0] c_ST_RUN  = 1'b1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]              r_state;
  logic [c_CW-1:0]         r_cnt;
  logic [c_PW-1:0]         r_wr_ptr;
  logic [c_PW-1:0]         r_rd_ptr;
  logic [c_OW-1:0]         r_count;
  logic                    r_full;
  logic                    r_busy;
  logic [1:0]              r_pht_op;
  logic [NUM_GHR_BITS-1:0] r_pht_addr;
  logic                    r_btb_we;
  logic                    r_btb_inval;
  logic [c_BI-1:0]         r_btb_addr;
  logic [31:0]             r_btb_target;
  logic [7:0]              r_dropped;

  // Records are stored already decoded into the commands they will issue.
  logic [1:0]              r_q_op    [FIFO_DEPTH];
  logic                    r_q_we    [FIFO_DEPTH];
  logic [NUM_GHR_BITS-1:0] r_q_paddr [FIFO_DEPTH];
  logic [c_BI-1:0]         r_q_baddr [FIFO_DEPTH];
  logic [31:0]             r_q_tgt   [FIFO_DEPTH];

  // --------------------------------------------------------------------------
  // Queue control
  // --------------------------------------------------------------------------
  logic                    w_push_req;
  logic                    w_pop_req;
  logic                    w_q_full;
  logic                    w_push_ok;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_drop;
  logic [c_OW-1:0]         w_count_nxt;
  logic [1:0]              w_in_op;
  logic                    w_in_we;
  logic [NUM_GHR_BITS-1:0] w_in_paddr;
  logic [c_BI-1:0]         w_in_baddr;
  logic                    w_unused_pc;

  assign w_push_req = upd_valid_i & (upd_branch_i | upd_jump_i);
  assign w_pop_req  = (r_state == c_ST_RUN) & (r_count != '0);
  assign w_q_full   = (r_count == c_FULL_CNT);
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign w_push_ok  = w_push_req & (~w_q_full | w_pop_req);
  // Flush discards same-cycle traffic without counting it as a drop.
  assign w_push     = w_push_ok & ~flush_i;
  assign w_pop      = w_pop_req & ~flush_i;
  assign w_drop     = w_push_req & ~w_push_ok & ~flush_i;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // A record with both flags set is a jump: no PHT training.
  assign w_in_op    = upd_jump_i ? c_OP_NOP : (upd_taken_i ? c_OP_INC : c_OP_DEC);
  assign w_in_we    = upd_jump_i | (upd_branch_i & upd_taken_i);
  assign w_in_paddr = upd_pc_i[NUM_GHR_BITS+1:2] ^ upd_ghr_i;
  assign w_in_baddr = upd_pc_i[c_BI+1:2];
  assign w_unused_pc = ^upd_pc_i;

  // Storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (reset_i && w_push) begin
      r_q_op[r_wr_ptr]    <= w_in_op;
      r_q_we[r_wr_ptr]    <= w_in_we;
      r_q_paddr[r_wr_ptr] <= w_in_paddr;
      r_q_baddr[r_wr_ptr] <= w_in_baddr;
      r_q_tgt[r_wr_ptr]   <= upd_target_i;
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM and registered command outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset_i) begin
      r_state      <= c_ST_INIT;
      r_cnt        <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_full       <= 1'b0;
      r_busy       <= 1'b1;
      r_pht_op     <= c_OP_NOP;
      r_pht_addr   <= '0;
      r_btb_we     <= 1'b0;
      r_btb_inval  <= 1'b0;
      r_btb_addr   <= '0;
      r_btb_target <= '0;
      r_dropped    <= '0;
    end else begin
      if (w_drop && (r_dropped != 8'hFF)) begin
        r_dropped <= r_dropped + 8'd1;
      end

      if (flush_i) begin
        r_state      <= c_ST_INIT;
        r_cnt        <= '0;
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
        r_count      <= '0;
        r_full       <= 1'b0;
        r_busy       <= 1'b1;
        r_pht_op     <= c_OP_NOP;
        r_pht_addr   <= '0;
        r_btb_we     <= 1'b0;
        r_btb_inval  <= 1'b0;
        r_btb_addr   <= '0;
        r_btb_target <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + 1'b1;
        end
        r_count <= w_count_nxt;
        r_full  <= (w_count_nxt == c_FULL_CNT);

        case (r_state)
          c_ST_INIT: begin
            // Sweep covers the larger table; the smaller one idles at the tail.
            r_busy       <= 1'b1;
            r_pht_op     <= (r_cnt < c_PHT_LIM) ? c_OP_INIT : c_OP_NOP;
            r_pht_addr   <= (r_cnt < c_PHT_LIM) ? r_cnt[NUM_GHR_BITS-1:0] : '0;
            r_btb_inval  <= (r_cnt < c_BTB_LIM);
            r_btb_addr   <= (r_cnt < c_BTB_LIM) ? r_cnt[c_BI-1:0] : '0;
            r_btb_we     <= 1'b0;
            r_btb_target <= '0;
            r_cnt        <= r_cnt + 1'b1;
            if (r_cnt == c_LAST_IDX) begin
              r_state <= c_ST_RUN;
            end
          end
          c_ST_RUN: begin
            r_busy      <= 1'b0;
            r_btb_inval <= 1'b0;
            if (w_pop) begin
              r_pht_op     <= r_q_op[r_rd_ptr];
              r_pht_addr   <= (r_q_op[r_rd_ptr] != c_OP_NOP) ? r_q_paddr[r_rd_ptr] : '0;
              r_btb_we     <= r_q_we[r_rd_ptr];
              r_btb_addr   <= r_q_we[r_rd_ptr] ? r_q_baddr[r_rd_ptr] : '0;
              r_btb_target <= r_q_we[r_rd_ptr] ? r_q_tgt[r_rd_ptr] : '0;
            end else begin
              r_pht_op     <= c_OP_NOP;
              r_pht_addr   <= '0;
              r_btb_we     <= 1'b0;
              r_btb_addr   <= '0;
              r_btb_target <= '0;
            end
          end
          default: begin
            r_state <= c_ST_INIT;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign upd_full_o   = r_full;
  assign busy_o       = r_busy;
  assign pht_op_o     = r_pht_op;
  assign pht_addr_o   = r_pht_addr;
  assign btb_we_o     = r_btb_we;
  assign btb_inval_o  = r_btb_inval;
  assign btb_addr_o   = r_btb_addr;
  assign btb_target_o = r_btb_target;
  assign dropped_o    = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_ucsbece154b_bpred_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ucsbece154b_bpred_ctrl
//  Purpose  : Self-checking bench for ucsbece154b_bpred_ctrl. Directed sweep,
//             table-driven RUN vectors, queue/flush/reset corner sequences and
//             a randomized phase, all compared against a queue-based model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ucsbece154b_bpred_ctrl;

  localparam int G     = 5;
  localparam int B     = 32;
  localparam int DEPTH = 4;
  localparam int SWEEP = 32;

  logic        clk;
  logic        reset_i;
  logic        flush_i;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic [G-1:0] upd_ghr_i;
  logic        upd_branch_i;
  logic        upd_jump_i;
  logic        upd_taken_i;
  logic [31:0] upd_target_i;
  logic        upd_full_o;
  logic        busy_o;
  logic [1:0]  pht_op_o;
  logic [G-1:0] pht_addr_o;
  logic        btb_we_o;
  logic        btb_inval_o;
  logic [4:0]  btb_addr_o;
  logic [31:0] btb_target_o;
  logic [7:0]  dropped_o;

  ucsbece154b_bpred_ctrl #(
    .NUM_GHR_BITS    (G),
    .NUM_BTB_ENTRIES (B),
    .FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk          (clk),
    .reset_i      (reset_i),
    .flush_i      (flush_i),
    .upd_valid_i  (upd_valid_i),
    .upd_pc_i     (upd_pc_i),
    .upd_ghr_i    (upd_ghr_i),
    .upd_branch_i (upd_branch_i),
    .upd_jump_i   (upd_jump_i),
    .upd_taken_i  (upd_taken_i),
    .upd_target_i (upd_target_i),
    .upd_full_o   (upd_full_o),
    .busy_o       (busy_o),
    .pht_op_o     (pht_op_o),
    .pht_addr_o   (pht_addr_o),
    .btb_we_o     (btb_we_o),
    .btb_inval_o  (btb_inval_o),
    .btb_addr_o   (btb_addr_o),
    .btb_target_o (btb_target_o),
    .dropped_o    (dropped_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // --------------------------------------------------------------------------
  // Reference model: pending records in a queue, sweep as a plain index.
  // --------------------------------------------------------------------------
  typedef struct {
    logic [31:0]  pc;
    logic [G-1:0] ghr;
    logic         br;
    logic         jp;
    logic         tk;
    logic [31:0]  tgt;
  } rec_t;

  rec_t q[$];
  bit   m_init  = 1'b1;
  int   m_sweep = 0;
  int   m_drop  = 0;
  logic [1:0]   e_op;
  logic [G-1:0] e_paddr;
  logic         e_we, e_inv, e_busy, e_full;
  logic [4:0]   e_baddr;
  logic [31:0]  e_tgt;

  task automatic model_edge();
    rec_t r;
    bit req, pop, acc;
    e_op = 2'd0; e_paddr = '0; e_we = 1'b0; e_inv = 1'b0; e_baddr = '0; e_tgt = '0;
    if (!reset_i) begin
      q.delete(); m_init = 1'b1; m_sweep = 0; m_drop = 0; e_busy = 1'b1; e_full = 1'b0;
      return;
    end
    if (flush_i) begin
      q.delete(); m_init = 1'b1; m_sweep = 0; e_busy = 1'b1; e_full = 1'b0;
      return;
    end
    req = upd_valid_i && (upd_branch_i || upd_jump_i);
    pop = !m_init && (q.size() > 0);
    acc = req && ((q.size() < DEPTH) || pop);
    if (req && !acc && m_drop < 255) m_drop++;
    e_busy = m_init;
    if (m_init) begin
      if (m_sweep < (1 << G)) begin e_op = 2'd1; e_paddr = G'(m_sweep); end
      if (m_sweep < B)        begin e_inv = 1'b1; e_baddr = 5'(m_sweep); end
      m_sweep++;
      if (m_sweep == SWEEP) m_init = 1'b0;
    end else if (pop) begin
      r = q.pop_front();
      if (r.br && !r.jp) begin
        e_op    = r.tk ? 2'd2 : 2'd3;
        e_paddr = r.pc[G+1:2] ^ r.ghr;
      end
      if (r.jp || (r.br && r.tk)) begin
        e_we = 1'b1; e_baddr = r.pc[6:2]; e_tgt = r.tgt;
      end
    end
    if (acc) begin
      r.pc = upd_pc_i; r.ghr = upd_ghr_i; r.br = upd_branch_i;
      r.jp = upd_jump_i; r.tk = upd_taken_i; r.tgt = upd_target_i;
      q.push_back(r);
    end
    e_full = (q.size() == DEPTH);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_model(input string name);
    logic [G-1:0] pa;
    logic [4:0]   ba;
    logic [31:0]  ta;
    pa = (e_op != 2'd0) ? pht_addr_o : '0;
    ba = (e_we || e_inv) ? btb_addr_o : 5'd0;
    ta = e_we ? btb_target_o : 32'd0;
    check(name,
          64'({pht_op_o, pa, btb_we_o, btb_inval_o, ba, ta, busy_o, upd_full_o, dropped_o}),
          64'({e_op, e_paddr, e_we, e_inv, e_baddr, e_tgt, e_busy, e_full, 8'(m_drop)}));
  endtask

  // Every clock edge goes through here so the model never falls behind.
  task automatic tick(input string name);
    model_edge();
    @(posedge clk);
    #1;
    compare_model(name);
  endtask

  task automatic drive(input logic v, input logic br, input logic jp, input logic tk,
                       input logic [31:0] pc, input logic [G-1:0] ghr, input logic [31:0] tgt);
    upd_valid_i = v; upd_branch_i = br; upd_jump_i = jp; upd_taken_i = tk;
    upd_pc_i = pc; upd_ghr_i = ghr; upd_target_i = tgt;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, '0, 32'd0);
  endtask

  task automatic check_reset_state(input string name);
    check(name,
          64'({pht_op_o, pht_addr_o, btb_we_o, btb_inval_o, btb_addr_o, btb_target_o, busy_o, upd_full_o, dropped_o}),
          64'({2'd0, 5'd0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 8'd0}));
  endtask

  task automatic check_sweep(input string name, input int k);
    check(name,
          64'({pht_op_o, pht_addr_o, btb_inval_o, btb_addr_o, btb_we_o, busy_o}),
          64'({2'd1, 5'(k), 1'b1, 5'(k), 1'b0, 1'b1}));
  endtask

  // --------------------------------------------------------------------------
  // Directed RUN vectors: inputs at an edge, outputs expected at that edge
  // (commands appear one edge after their push).
  // --------------------------------------------------------------------------
  typedef struct {
    logic         v, br, jp, tk;
    logic [31:0]  pc;
    logic [G-1:0] ghr;
    logic [31:0]  tgt;
    logic [1:0]   e_op;
    logic [G-1:0] e_paddr;
    logic         e_we;
    logic [4:0]   e_baddr;
    logic [31:0]  e_tgt;
  } vec_t;

  function automatic vec_t mkv(input logic v, input logic br, input logic jp, input logic tk,
                               input logic [31:0] pc, input logic [G-1:0] ghr, input logic [31:0] tgt,
                               input logic [1:0] eo, input logic [G-1:0] ep, input logic ew,
                               input logic [4:0] eb, input logic [31:0] et);
    vec_t x;
    x.v = v; x.br = br; x.jp = jp; x.tk = tk; x.pc = pc; x.ghr = ghr; x.tgt = tgt;
    x.e_op = eo; x.e_paddr = ep; x.e_we = ew; x.e_baddr = eb; x.e_tgt = et;
    return x;
  endfunction

  vec_t tbl[11];

  initial begin
    tbl[0]  = mkv(1'b1, 1'b1, 1'b0, 1'b1, 32'h40, 5'h03, 32'h100, 2'd0, 5'h00, 1'b0, 5'd0,  32'h0);
    tbl[1]  = mkv(1'b1, 1'b1, 1'b0, 1'b0, 32'h44, 5'h00, 32'h48,  2'd2, 5'h13, 1'b1, 5'd16, 32'h100);
    tbl[2]  = mkv(1'b1, 1'b0, 1'b1, 1'b0, 32'h80, 5'h00, 32'h200, 2'd3, 5'h11, 1'b0, 5'd0,  32'h0);
    tbl[3]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  5'h00, 32'h0,   2'd0, 5'h00, 1'b1, 5'd0,  32'h200);
    tbl[4]  = mkv(1'b1, 1'b1, 1'b1, 1'b1, 32'h8C, 5'h07, 32'h300, 2'd0, 5'h00, 1'b0, 5'd0,  32'h0);
    tbl[5]  = mkv(1'b1, 1'b0, 1'b0, 1'b1, 32'h10, 5'h00, 32'h999, 2'd0, 5'h00, 1'b1, 5'd3,  32'h300);
    tbl[6]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  5'h00, 32'h0,   2'd0, 5'h00, 1'b0, 5'd0,  32'h0);
    tbl[7]  = mkv(1'b1, 1'b1, 1'b0, 1'b1, 32'h7C, 5'h1F, 32'h0,   2'd0, 5'h00, 1'b0, 5'd0,  32'h0);
    tbl[8]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  5'h00, 32'h0,   2'd2, 5'h00, 1'b1, 5'd31, 32'h0);
    tbl[9]  = mkv(1'b0, 1'b1, 1'b0, 1'b1, 32'h50, 5'h00, 32'h60,  2'd0, 5'h00, 1'b0, 5'd0,  32'h0);
    tbl[10] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,  5'h00, 32'h0,   2'd0, 5'h00, 1'b0, 5'd0,  32'h0);

    reset_i = 1'b0;
    flush_i = 1'b0;
    idle();

    // Reset state and a full sweep.
    tick("reset");
    tick("reset");
    check_reset_state("reset_state");
    reset_i = 1'b1;
    for (int k = 0; k < SWEEP; k++) begin
      tick("sweep");
      check_sweep($sformatf("sweep_idx%0d", k), k);
    end
    tick("run_entry");
    check("run_entry", 64'({busy_o, pht_op_o, btb_we_o, btb_inval_o}), 64'({1'b0, 2'd0, 1'b0, 1'b0}));

    // Table-driven RUN vectors.
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].v, tbl[i].br, tbl[i].jp, tbl[i].tk, tbl[i].pc, tbl[i].ghr, tbl[i].tgt);
      tick("table");
      check($sformatf("vec%0d_cmd", i),
            64'({pht_op_o, (tbl[i].e_op != 2'd0) ? pht_addr_o : 5'd0, btb_we_o,
                 tbl[i].e_we ? btb_addr_o : 5'd0, tbl[i].e_we ? btb_target_o : 32'd0}),
            64'({tbl[i].e_op, tbl[i].e_paddr, tbl[i].e_we, tbl[i].e_baddr, tbl[i].e_tgt}));
    end
    idle();

    // Five pushes during the sweep: four queue, the fifth is dropped.
    reset_i = 1'b0;
    tick("reset2");
    reset_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'(i % 2), 32'h100 + 32'(4 * i), 5'h00, 32'h1000 + 32'(i));
      tick("init_push");
      if (i == 2) check("full_after_3", 64'(upd_full_o), 64'(1'b0));
      if (i == 3) check("full_after_4", 64'(upd_full_o), 64'(1'b1));
      if (i == 4) check("dropped_after_5", 64'({upd_full_o, dropped_o}), 64'({1'b1, 8'd1}));
    end
    idle();
    for (int k = 5; k < SWEEP; k++) tick("init_wait");
    for (int i = 0; i < 4; i++) begin
      tick("drain");
      check($sformatf("drain%0d", i),
            64'({busy_o, pht_op_o, pht_addr_o, btb_we_o, upd_full_o}),
            64'({1'b0, (i % 2 == 1) ? 2'd2 : 2'd3, 5'(i), 1'(i % 2), 1'b0}));
    end
    tick("drain_end");
    check("drain_end", 64'({pht_op_o, btb_we_o}), 64'({2'd0, 1'b0}));

    // Held flush restarts every cycle; then a flush with a backlog and a push.
    flush_i = 1'b1;
    tick("flush_a");
    check("flush_held_a", 64'({pht_op_o, btb_inval_o, btb_we_o, busy_o}), 64'({2'd0, 1'b0, 1'b0, 1'b1}));
    tick("flush_b");
    check("flush_held_b", 64'({pht_op_o, btb_inval_o, btb_we_o, busy_o}), 64'({2'd0, 1'b0, 1'b0, 1'b1}));
    flush_i = 1'b0;
    for (int k = 0; k < SWEEP; k++) begin
      if (k < 2) drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h200 + 32'(4 * k), 5'h00, 32'h2000);
      else idle();
      tick("flush_sweep");
      if (k == 0) check_sweep("flush_sweep_idx0", 0);
    end
    flush_i = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h300, 5'h00, 32'h3000);
    tick("flush_backlog");
    check("flush_backlog", 64'({pht_op_o, btb_we_o, busy_o, upd_full_o, dropped_o}),
          64'({2'd0, 1'b0, 1'b1, 1'b0, 8'd1}));
    flush_i = 1'b0;
    idle();
    tick("flush_restart");
    check_sweep("flush_restart_idx0", 0);
    for (int k = 1; k < SWEEP; k++) tick("flush_resweep");
    tick("flush_after");
    check("flush_nothing_issued", 64'({busy_o, pht_op_o, btb_we_o, dropped_o}), 64'({1'b0, 2'd0, 1'b0, 8'd1}));

    // Reset mid-sweep with dropped_o = 3.
    reset_i = 1'b0;
    tick("reset3");
    reset_i = 1'b1;
    for (int k = 0; k < 11; k++) begin
      if (k < 7) drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h400 + 32'(4 * k), 5'h00, 32'h0);
      else idle();
      tick("mid_sweep");
    end
    check("mid_sweep_state", 64'({pht_addr_o, dropped_o, upd_full_o}), 64'({5'd10, 8'd3, 1'b1}));
    reset_i = 1'b0;
    tick("mid_reset");
    check_reset_state("mid_reset_state");
    reset_i = 1'b1;
    tick("mid_restart");
    check_sweep("mid_restart_idx0", 0);
    for (int k = 1; k <= SWEEP + 2; k++) tick("mid_finish");

    // Randomized phase against the model.
    for (int n = 0; n < 3000; n++) begin
      reset_i = ($urandom_range(0, 499) != 0);
      flush_i = ($urandom_range(0, 63) == 0);
      drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom, G'($urandom), $urandom);
      tick("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ucsbece154b_bpred_ctrl.md
# ucsbece154b_bpred_ctrl

Maintenance controller for the branch predictor's PHT and BTB. After reset or on a flush, it sweeps both tables to a known state. In normal operation, it queues branch/jump resolutions from the E stage and serializes them onto the single PHT and BTB write ports, one update per cycle. It sits between the E-stage resolution logic and the predictor tables, and tells fetch when predictions are usable.

## Interface
- NUM_GHR_BITS, 5, PHT index width; PHT has 2^NUM_GHR_BITS entries
- NUM_BTB_ENTRIES, 32, BTB entries; power of 2, BTB index width BI = log2(NUM_BTB_ENTRIES)
- FIFO_DEPTH, 4, update-queue depth; power of 2, at least 2

- clk  in  1  single clock; everything updates on its rising edge
- reset_i  in  1  synchronous, active-low reset
- flush_i  in  1  restart the table sweep and discard queued updates
- upd_valid_i  in  1  E-stage resolution record valid this cycle
- upd_pc_i  in  32  PC of the resolved instruction
- upd_ghr_i  in  NUM_GHR_BITS  GHR value used when the instruction was predicted
- upd_branch_i  in  1  record is a conditional branch
- upd_jump_i  in  1  record is jal/jalr
- upd_taken_i  in  1  resolved direction (branch only)
- upd_target_i  in  32  resolved target (PCTargetE)
- upd_full_o  out  1  queue holds FIFO_DEPTH records
- busy_o  out  1  sweep in progress; fetch must not use predictions
- pht_op_o  out  2  0 = NOP, 1 = INIT (write weakly-not-taken 2'b01), 2 = INC, 3 = DEC (saturating, done in the PHT)
- pht_addr_o  out  NUM_GHR_BITS  PHT index for pht_op_o
- btb_we_o  out  1  write BTB entry: valid=1, target=btb_target_o
- btb_inval_o  out  1  clear the valid bit of the BTB entry
- btb_addr_o  out  BI  BTB index
- btb_target_o  out  32  BTB write data
- dropped_o  out  8  saturating count of updates lost to a full queue

## Operation
- States: INIT and RUN. Reset forces INIT with sweep counter cnt=0, an empty queue and dropped_o=0.
- INIT
  - Each cycle, issue a command for index cnt, then increment cnt. Sweep length S = max(2^NUM_GHR_BITS, NUM_BTB_ENTRIES).
  - If cnt < 2^NUM_GHR_BITS: pht_op=INIT, pht_addr=cnt[NUM_GHR_BITS-1:0]; otherwise NOP.
  - If cnt < NUM_BTB_ENTRIES: btb_inval=1, btb_addr=cnt[BI-1:0].
  - After issuing cnt=S-1, go to RUN. The queue is not drained during INIT.
- RUN
  - If the queue is non-empty, pop the head, one record per cycle. Commands for the popped record:
    - branch: pht_op = taken ? INC : DEC, pht_addr = upd_pc[NUM_GHR_BITS+1:2] ^ upd_ghr.
    - BTB write when jump, or branch and taken: btb_we=1, btb_addr=upd_pc[BI+1:2], btb_target=upd_target.
    - Otherwise all write outputs idle.
- Push rules
  - A push happens on upd_valid_i & (upd_branch_i | upd_jump_i). Records with neither flag set are ignored and not counted.
  - A push is accepted if the queue is not full, or if a pop occurs in the same cycle.
  - An otherwise rejected push increments dropped_o, which saturates at 255.
  - Pushes are accepted in both INIT and RUN.
- flush_i, from either state:
  - Next state is INIT, cnt=0, queue emptied.
  - A push or pop in the same cycle is discarded and not counted.
  - dropped_o is kept.
  - flush_i held high restarts the sweep every cycle.
- branch and jump both set: treat the record as a jump (no PHT op).

## Timing
- All outputs are registered. Reset values:
  - pht_op_o=0, pht_addr_o=0, btb_we_o=0, btb_inval_o=0, btb_addr_o=0, btb_target_o=0, upd_full_o=0, dropped_o=0.
  - busy_o=1.
- Sweep timing:
  - Edge 1 after reset_i goes high presents the command for index 0.
  - Edge k presents the command for index k-1.
  - Edge S+1 presents the first RUN-state outputs and busy_o=0.
- Push-to-command latency:
  - A record pushed at edge t into an empty queue in RUN appears on the outputs at edge t+1. There is no same-cycle bypass.
  - With a queue backlog, one record is issued per cycle in FIFO order.
- upd_full_o reflects the occupancy after each edge.
- Reset mid-sweep or mid-drain restores the full reset state, including dropped_o=0.
- Flush at edge t:
  - Edge t itself presents NOP outputs with busy_o=1.
  - Edge t+1 presents the command for index 0.

## Test plan
- Reset with the defaults (G=5, B=32), then release:
  - Edges 1..32 show pht_op=1 and btb_inval=1, with addr 0..31.
  - Edge 33 shows busy_o=0 and NOP.
- In RUN, push a taken branch (pc=0x40, ghr=5'b00011, target=0x100) at edge t:
  - Edge t+1 shows pht_op=2, pht_addr=0x13, btb_we=1, btb_addr=16, btb_target=0x100.
- Push a not-taken branch (pc=0x44, ghr=0), then a jump (pc=0x80, target=0x200) on back-to-back cycles:
  - Consecutive edges show {DEC, addr 0x11, btb_we=0} then {NOP, btb_we=1, btb_addr=0, target 0x200}.
- During INIT, push 5 branch records:
  - upd_full_o=1 after the 4th push; dropped_o=1.
  - After the sweep, the 4 accepted records issue on 4 consecutive edges in push order.
- In RUN with 2 records queued, pulse flush_i together with a push:
  - No queued update is issued; dropped_o is unchanged.
  - The sweep restarts at index 0 on the following edge.
- Assert reset_i low at sweep index 10 with dropped_o=3, then release:
  - All outputs return to their reset values and dropped_o=0.
  - The sweep restarts from index 0.
